// File: rtl/video_timing_ctrl_if.sv
// Pixel-fetch and encoder-facing signal bundle for the raster sequencer.
// master = sequencer side, slave = pixel source / encoder / controller side.
interface video_timing_ctrl_if #(
    parameter int CNT_W = 11
);
    logic             enable;
    logic             pix_valid;
    logic [CNT_W-1:0] pix_x;
    logic [CNT_W-1:0] pix_y;
    logic [2:0]       pix_red;
    logic [2:0]       pix_green;
    logic [2:0]       pix_blue;
    logic             hsync;
    logic             vsync;
    logic             blank;
    logic [2:0]       red;
    logic [2:0]       green;
    logic [2:0]       blue;
    logic             frame_start;
    logic             line_start;
    logic             running;

    modport master (
        input  enable, pix_red, pix_green, pix_blue,
        output pix_valid, pix_x, pix_y,
        output hsync, vsync, blank, red, green, blue,
        output frame_start, line_start, running
    );

    modport slave (
        output enable, pix_red, pix_green, pix_blue,
        input  pix_valid, pix_x, pix_y,
        input  hsync, vsync, blank, red, green, blue,
        input  frame_start, line_start, running
    );
endinterface

// File: rtl/video_timing_ctrl.sv
// Raster sequencer: programmable H/V timing, pixel fetch PREFETCH clks ahead, sync/blank delayed to meet colour.
// Latency: request to encoder output is PREFETCH clks. No backpressure; starts/stops only on frame boundaries.
module video_timing_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int PREFETCH  = 2,
    parameter int CNT_W     = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    video_timing_ctrl_if.master  vt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
        logic frame_start;
        logic line_start;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{
        hsync:       ~HSYNC_POL,
        vsync:       ~VSYNC_POL,
        blank:       1'b1,
        frame_start: 1'b0,
        line_start:  1'b0
    };

    state_t           state;
    logic             run_q;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_last;
    logic             v_last;
    logic             active;
    ctl_t             ctl_dec;
    ctl_t             ctl_q [PREFETCH];
    logic [8:0]       col_q;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);
    assign active = run_q && (h_cnt < H_ACT) && (v_cnt < V_ACT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            run_q <= 1'b0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    h_cnt <= '0;
                    v_cnt <= '0;
                    if (vt.enable) begin
                        state <= RUN;
                        run_q <= 1'b1;
                    end
                end
                default: begin
                    if (h_last) begin
                        h_cnt <= '0;
                        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
                    end else begin
                        h_cnt <= h_cnt + 1'b1;
                    end
                    // Leaving DRAIN early keeps the counters untouched, so re-enable is seamless.
                    if (state == RUN) begin
                        if (!vt.enable) state <= DRAIN;
                    end else if (vt.enable) begin
                        state <= RUN;
                    end else if (h_last && v_last) begin
                        state <= IDLE;
                        run_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign vt.pix_valid = active;
    assign vt.pix_x     = active ? h_cnt : '0;
    assign vt.pix_y     = active ? v_cnt : '0;
    assign vt.running   = run_q;

    always_comb begin
        ctl_dec = CTL_IDLE;
        if (run_q) begin
            ctl_dec.hsync       = (h_cnt >= HS_BEG && h_cnt < HS_END) ? HSYNC_POL : ~HSYNC_POL;
            ctl_dec.vsync       = (v_cnt >= VS_BEG && v_cnt < VS_END) ? VSYNC_POL : ~VSYNC_POL;
            ctl_dec.blank       = ~active;
            ctl_dec.frame_start = (h_cnt == '0) && (v_cnt == '0);
            ctl_dec.line_start  = (h_cnt == '0) && (v_cnt < V_ACT);
        end
    end

    // Control stages keep shifting in IDLE so the tail of the last frame flushes out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PREFETCH; i++) ctl_q[i] <= CTL_IDLE;
            col_q <= '0;
        end else begin
            ctl_q[0] <= ctl_dec;
            for (int i = 1; i < PREFETCH; i++) ctl_q[i] <= ctl_q[i-1];
            col_q <= {vt.pix_red, vt.pix_green, vt.pix_blue};
        end
    end

    assign vt.hsync       = ctl_q[PREFETCH-1].hsync;
    assign vt.vsync       = ctl_q[PREFETCH-1].vsync;
    assign vt.blank       = ctl_q[PREFETCH-1].blank;
    assign vt.frame_start = ctl_q[PREFETCH-1].frame_start;
    assign vt.line_start  = ctl_q[PREFETCH-1].line_start;
    assign vt.red         = ctl_q[PREFETCH-1].blank ? 3'b000 : col_q[8:6];
    assign vt.green       = ctl_q[PREFETCH-1].blank ? 3'b000 : col_q[5:3];
    assign vt.blue        = ctl_q[PREFETCH-1].blank ? 3'b000 : col_q[2:0];
endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl on a 14x8 raster: pixel scoreboard plus directed timing checks.
module tb_video_timing_ctrl;
    localparam int CNT_W = 11;
    localparam int NLOG  = 400;

    logic clk;
    logic reset;

    video_timing_ctrl_if #(.CNT_W(CNT_W)) vt();

    video_timing_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .PREFETCH(2), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .vt    (vt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests_run = 0;
    int tests_failed = 0;
    bit sb_on = 1'b0;

    logic [21:0] req_q[$];
    logic [8:0]  pix_q[$];

    bit hs_log [NLOG];
    bit vs_log [NLOG];
    bit bl_log [NLOG];
    bit fs_log [NLOG];
    bit ls_log [NLOG];
    bit pv_log [NLOG];
    bit rn_log [NLOG];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [8:0] colour(input logic [CNT_W-1:0] x, input logic [CNT_W-1:0] y);
        logic [2:0] xr;
        logic [2:0] yr;
        xr = x[2:0];
        yr = y[2:0];
        return {xr, yr, ~xr};
    endfunction

    task automatic push_frame();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++) begin
                req_q.push_back({CNT_W'(x), CNT_W'(y)});
                pix_q.push_back(colour(CNT_W'(x), CNT_W'(y)));
            end
    endtask

    task automatic log_at(input int r);
        hs_log[r] = vt.hsync;
        vs_log[r] = vt.vsync;
        bl_log[r] = vt.blank;
        fs_log[r] = vt.frame_start;
        ls_log[r] = vt.line_start;
        pv_log[r] = vt.pix_valid;
        rn_log[r] = vt.running;
    endtask

    // Pixel source: answers a request seen in cycle n during cycle n+1.
    initial begin
        logic [CNT_W-1:0] sx;
        logic [CNT_W-1:0] sy;
        logic             sv;
        logic [8:0]       c;
        vt.pix_red = '0; vt.pix_green = '0; vt.pix_blue = '0;
        forever begin
            @(negedge clk);
            sx = vt.pix_x; sy = vt.pix_y; sv = vt.pix_valid;
            @(posedge clk);
            #1;
            c = sv ? colour(sx, sy) : 9'h1FF;
            vt.pix_red = c[8:6]; vt.pix_green = c[5:3]; vt.pix_blue = c[2:0];
        end
    end

    // Request monitor.
    initial begin
        logic [21:0] e;
        forever begin
            @(negedge clk);
            if (vt.pix_valid) begin
                if (sb_on) begin
                    if (req_q.size() == 0) check("req_q_underflow", 1, 0);
                    else begin
                        e = req_q.pop_front();
                        check("req_coord", {vt.pix_x, vt.pix_y}, e);
                    end
                end
            end else begin
                check("req_idle_coord", {vt.pix_x, vt.pix_y}, 0);
            end
        end
    end

    // Output monitor.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (vt.blank) begin
                check("rgb_blanked", {vt.red, vt.green, vt.blue}, 0);
            end else if (sb_on) begin
                if (pix_q.size() == 0) check("pix_q_underflow", 1, 0);
                else begin
                    e = pix_q.pop_front();
                    check("rgb_pixel", {vt.red, vt.green, vt.blue}, e);
                end
            end
        end
    end

    initial begin
        int cnt;
        int fpos[$];
        logic [31:0] hs_exp;

        reset = 1'b1;
        vt.enable = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hsync", vt.hsync, 1);
        check("rst_vsync", vt.vsync, 1);
        check("rst_blank", vt.blank, 1);
        check("rst_rgb", {vt.red, vt.green, vt.blue}, 0);
        check("rst_pix_valid", vt.pix_valid, 0);
        check("rst_running", vt.running, 0);
        check("rst_pulses", {vt.frame_start, vt.line_start}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Three frames: drop/raise mid frame 2, drop at line 2 h=3 of frame 3.
        push_frame(); push_frame(); push_frame();
        sb_on = 1'b1;
        vt.enable = 1'b1;
        log_at(0);
        for (int r = 1; r < NLOG; r++) begin
            @(negedge clk);
            log_at(r);
            if (r == 150) vt.enable = 1'b0;
            if (r == 155) vt.enable = 1'b1;
            if (r == 256) vt.enable = 1'b0;
        end

        for (int r = 0; r <= 9; r++) check($sformatf("pix_valid_rel%0d", r), pv_log[r], (r >= 1 && r <= 8));
        check("blank_rel2", bl_log[2], 1);
        check("blank_rel3", bl_log[3], 0);
        check("fs_rel2", fs_log[2], 0);
        check("fs_rel3", fs_log[3], 1);
        hs_exp = 32'b10001;
        for (int r = 12; r <= 16; r++) check($sformatf("hsync_rel%0d", r), hs_log[r], hs_exp[16 - r]);

        cnt = 0;
        for (int r = 3; r <= 114; r++) if (!vs_log[r]) cnt++;
        check("vsync_low_clks", cnt, 28);
        check("vsync_rel72", vs_log[72], 1);
        check("vsync_rel73", vs_log[73], 0);
        check("vsync_rel100", vs_log[100], 0);
        check("vsync_rel101", vs_log[101], 1);
        cnt = 0;
        for (int r = 3; r <= 114; r++) if (ls_log[r]) cnt++;
        check("line_start_count", cnt, 4);
        for (int r = 0; r < NLOG; r++) if (fs_log[r]) fpos.push_back(r);
        check("frame_start_count", fpos.size(), 3);
        if (fpos.size() == 3) begin
            check("frame_start_1", fpos[0], 3);
            check("frame_start_2", fpos[1], 115);
            check("frame_start_3", fpos[2], 227);
        end

        check("running_rel336", rn_log[336], 1);
        check("running_rel337", rn_log[337], 0);
        cnt = 0;
        for (int r = 337; r < NLOG; r++) if (pv_log[r]) cnt++;
        check("pix_valid_after_stop", cnt, 0);
        check("idle_out_rel338", {hs_log[338], vs_log[338], bl_log[338]}, 3'b111);
        check("idle_out_end", {hs_log[NLOG-1], vs_log[NLOG-1], bl_log[NLOG-1]}, 3'b111);
        check("req_q_drained", req_q.size(), 0);
        check("pix_q_drained", pix_q.size(), 0);

        // Reset mid active pixel.
        sb_on = 1'b0;
        req_q.delete();
        pix_q.delete();
        @(negedge clk);
        vt.enable = 1'b1;
        repeat (20) @(negedge clk);
        check("pre_reset_active", vt.blank, 0);
        #2 reset = 1'b1;
        #1;
        check("arst_blank", vt.blank, 1);
        check("arst_syncs", {vt.hsync, vt.vsync}, 2'b11);
        check("arst_rgb", {vt.red, vt.green, vt.blue}, 0);
        check("arst_pix_valid", vt.pix_valid, 0);
        check("arst_running", vt.running, 0);
        vt.enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Restart: one full frame from (0,0).
        push_frame();
        sb_on = 1'b1;
        vt.enable = 1'b1;
        log_at(0);
        for (int r = 1; r <= 130; r++) begin
            @(negedge clk);
            log_at(r);
            if (r == 50) vt.enable = 1'b0;
        end
        check("restart_pix_valid_rel1", pv_log[1], 1);
        check("restart_fs_rel3", fs_log[3], 1);
        check("restart_blank_rel3", bl_log[3], 0);
        check("restart_running_rel112", rn_log[112], 1);
        check("restart_running_rel113", rn_log[113], 0);
        check("restart_req_q_drained", req_q.size(), 0);
        check("restart_pix_q_drained", pix_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/video_timing_ctrl.md
Name: video_timing_ctrl

Overview:
Raster sequencer that drives the DVI symbol encoder's hsync, vsync, blank and 3-bit red/green/blue inputs in the pixel-clock (clk) domain. It generates programmable horizontal and vertical timing and issues pixel-coordinate fetch requests PREFETCH cycles ahead to a pixel source (framebuffer or pattern generator). It delays sync and blank to align with the returned colour. It starts and stops only on frame boundaries, so the encoder never sees a truncated frame.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clks)
H_SYNC, 96, hsync width (clks)
H_BP, 48, horizontal back porch (clks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, asserted level of hsync
VSYNC_POL, 0, asserted level of vsync
PREFETCH, 2, request-to-output latency in clks; legal range 1..4
CNT_W, 11, width of counters and coordinate outputs

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run request; sampled every clk
pix_valid  out  1  fetch request; coordinate is inside the active area
pix_x  out  CNT_W  requested column
pix_y  out  CNT_W  requested row
pix_red  in  3  colour returned by the source for the request
pix_green  in  3  as above
pix_blue  in  3  as above
hsync  out  1  to encoder
vsync  out  1  to encoder
blank  out  1  to encoder; 1 selects control symbols
red  out  3  to encoder
green  out  3  to encoder
blue  out  3  to encoder
frame_start  out  1  1-clk pulse aligned with output of pixel (0,0)
line_start  out  1  1-clk pulse aligned with output of column 0 of each active line
running  out  1  state is RUN or DRAIN

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL analogous. Both must be less than 2^CNT_W.
- Line order is active, front porch, sync, back porch.
- Reset (async) values:
  - state=IDLE; h_cnt=0; v_cnt=0; all delay stages cleared.
  - hsync=~HSYNC_POL; vsync=~VSYNC_POL; blank=1; red/green/blue=0.
  - pix_valid=0; pix_x=0; pix_y=0; frame_start=0; line_start=0; running=0.
- States:
  - IDLE: counters held at 0, request timeline inactive. enable=1 moves to RUN; the next clk is h=0,v=0.
  - RUN: h_cnt increments each clk and wraps at H_TOTAL-1. On wrap, v_cnt increments and wraps at V_TOTAL-1. If enable=0 at any clk, move to DRAIN.
  - DRAIN: keeps counting. If enable=1 again, return to RUN with no timing disturbance. At the last clk of the frame (h=H_TOTAL-1, v=V_TOTAL-1) go to IDLE.
  - An enable toggle mid-frame never truncates or restarts a frame.
- Request timeline (counter cycle n):
  - pix_valid = running and h<H_ACTIVE and v<V_ACTIVE.
  - pix_x=h and pix_y=v when pix_valid; otherwise both 0.
- Source contract: colour for the request issued in cycle n is presented on pix_* during cycle n+PREFETCH-1. The block registers it.
- Output timeline:
  - Sync, blank, frame_start and line_start are decoded from the cycle-n counters and pass through PREFETCH register stages, so they appear at cycle n+PREFETCH together with the registered colour.
  - In IDLE, decoded values are the reset values; the pipeline keeps shifting so the tail of the last frame flushes out.
- Decodes:
  - hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted for whole lines V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
  - blank = not (h<H_ACTIVE and v<V_ACTIVE and running).
- Colour gating: red/green/blue are forced to 0 whenever the aligned blank=1. pix_* are ignored then.
- Pulses:
  - frame_start decoded at h=0,v=0 while running.
  - line_start decoded at h=0, v<V_ACTIVE while running.
- Reset asserted mid-frame: all outputs return to reset values immediately. No completion of the frame.

Test Plan:
Small config for all tests: H 8/2/3/1 (H_TOTAL=14), V 4/1/2/1 (V_TOTAL=8), PREFETCH=2, POL=0.
1. Reset, enable=1 from clk 0 -> pix_valid=1 clks 1..8 with pix_x 0..7 and pix_y=0. blank=0 and frame_start=1 at clk 3. hsync=0 for output clks 13..15 (h 10..12 + 2).
2. Source returns pix_red=pix_x[2:0] with the contracted latency -> red sequence 0..7 during blank=0 on every active line; red=0 whenever blank=1.
3. Full frame -> vsync=0 for exactly 28 clks (lines 5–6). frame_start pulses every 112 clks. line_start pulses 4 times per frame.
4. enable dropped at line 2, h=3 -> frame completes through v=7, h=13. running falls after that clk. Outputs return to idle levels 2 clks later; no further pix_valid.
5. enable dropped then re-raised within the same frame -> no change in timing. frame_start period stays 112.
6. Async reset asserted mid-active-pixel -> blank=1, hsync=vsync=1, rgb=0, pix_valid=0 in the same cycle. Restart with enable=1 gives a full frame from (0,0).
